// File: rtl/lut_sched_pkg.sv
// Shared types and sizing for the LUT layer scheduler.
// Holds the FSM state type, config selectors and default widths.
package lut_sched_pkg;

  localparam int IN_WIDTH_D    = 64;
  localparam int NUM_NEURONS_D = 16;
  localparam int FANIN_D       = 8;

  localparam int CNT_W  = $clog2(NUM_NEURONS_D);
  localparam int SLOT_W = $clog2(FANIN_D);
  localparam int MEM_AW = CNT_W + FANIN_D;

  localparam logic CFG_SEL_LUT = 1'b0;
  localparam logic CFG_SEL_IDX = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/lut_sched_tt_mem.sv
// Shared truth-table RAM: one write port, one registered read port.
// Contents are never reset so tables survive a layer reset.
module lut_sched_tt_mem
  import lut_sched_pkg::*;
#(
  parameter int AW = MEM_AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  (* rom_style = "distributed" *)
  logic mem [2**AW];

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Evaluates one LogicNets layer neuron-by-neuron through a shared LUT.
// Fan-in gather, index table and sequencing FSM live here.
module lut_layer_scheduler
  import lut_sched_pkg::*;
#(
  parameter int IN_WIDTH    = IN_WIDTH_D,
  parameter int NUM_NEURONS = NUM_NEURONS_D,
  parameter int FANIN       = FANIN_D,
  parameter int IDX_W       = $clog2(IN_WIDTH),
  localparam int NW         = $clog2(NUM_NEURONS),
  localparam int WDW        = $clog2(IN_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  input  logic                   cfg_we,
  input  logic                   cfg_sel,
  input  logic [NW-1:0]          cfg_neuron,
  input  logic [FANIN-1:0]       cfg_addr,
  input  logic [WDW-1:0]         cfg_wdata,
  output logic                   cfg_err
);

  localparam int SW = (FANIN > 1) ? $clog2(FANIN) : 1;
  localparam int AW = NW + FANIN;

  state_t              state;
  logic [IN_WIDTH-1:0] vec;
  logic [NW-1:0]       cnt;
  logic [NW-1:0]       prev;
  logic [IDX_W-1:0]    idx_tab [NUM_NEURONS][FANIN];
  logic [FANIN-1:0]    lut_addr;
  logic [SW-1:0]       slot;
  logic                rd_bit;
  logic                take;
  logic                cfg_ok;
  logic                idx_bad;
  logic                lut_we;
  logic                idx_we;

  // cfg_wdata is one bit wider than an index so that
  // out-of-range indices can be seen and rejected.
  assign take    = in_valid && in_ready && (state == IDLE);
  assign cfg_ok  = cfg_we && !rst && (state == IDLE);
  assign idx_bad = (int'(cfg_addr) >= FANIN)
                || (int'(cfg_wdata) >= IN_WIDTH);
  assign lut_we  = cfg_ok && (cfg_sel == CFG_SEL_LUT);
  assign idx_we  = cfg_ok && (cfg_sel == CFG_SEL_IDX) && !idx_bad;
  assign slot    = cfg_addr[SW-1:0];
  assign prev    = cnt - 1'b1;

  // gather the current neuron's fan-in bits into a LUT row
  always_comb begin
    lut_addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      lut_addr[k] = vec[idx_tab[cnt][k]];
    end
  end

  // fan-in index table, persistent across reset
  always_ff @(posedge clk) begin
    if (idx_we) begin
      idx_tab[cfg_neuron][slot] <= cfg_wdata[IDX_W-1:0];
    end
  end

  lut_sched_tt_mem #(
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .we   (lut_we),
    .waddr({cfg_neuron, cfg_addr}),
    .wdata(cfg_wdata[0]),
    .re   (state == RUN),
    .raddr({cnt, lut_addr}),
    .rdata(rd_bit)
  );

  // sequencing FSM with registered handshake and error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      cfg_err <= cfg_we && ((state != IDLE)
              || ((cfg_sel == CFG_SEL_IDX) && idx_bad));
      unique case (state)
        IDLE: begin
          if (take) begin
            vec      <= in_data;
            out_data <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (cnt != '0) out_data[prev] <= rd_bit;
          cnt <= cnt + 1'b1;
          if (cnt == NW'(NUM_NEURONS - 1)) state <= DRAIN;
        end
        DRAIN: begin
          out_data[NUM_NEURONS-1] <= rd_bit;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
